symmetric_fir_param: RTL and testbench

- Parametrised symmetric (linear-phase) FIR filter in broadcast/transposed form.
- Folds the impulse response so only ceil(NUM_TAPS/2) multipliers are built; supports odd and even tap counts.
- Coefficients load at run time into a shadow bank and are committed atomically, so the active bank never changes mid-stream.
- Full-precision accumulation, then round-half-up and optional saturation to the output width. Drop-in next generation of the fixed 172-tap filter in the course-project datapath.

---
 rtl/fir_pkg.sv | 65 ++++++
 rtl/fir_round_sat.sv | 26 ++
 rtl/symmetric_fir_param.sv | 106 ++++++++++
 tb/tb_symmetric_fir_param.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared sizing helpers and the output rounding/saturation function for the
// symmetric FIR filter.
package fir_pkg;

  // Widest accumulator the rounding function can handle internally.
  localparam int MAX_W = 128;

  // Ceiling log2 of value; 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int b = 0; b < 31; b++) begin
      if ((1 << b) < value) r = b + 1;
    end
    return r;
  endfunction

  // Number of physical multipliers after folding the symmetric response.
  function automatic int num_mults(input int taps);
    return (taps + 1) / 2;
  endfunction

  // Coefficient address width; never zero, even when only one multiplier exists.
  function automatic int addr_width(input int taps);
    int m;
    m = num_mults(taps);
    return (m > 1) ? clog2(m) : 1;
  endfunction

  // Full-precision accumulator width, large enough for NUM_TAPS worst-case products.
  function automatic int acc_width(input int data_w, input int coeff_w, input int taps);
    return data_w + coeff_w + clog2(taps);
  endfunction

  // Round half-up after an arithmetic right shift, then clamp to out_w bits
  // when saturating. When wrapping, the caller keeps the low out_w bits.
  function automatic logic signed [MAX_W-1:0] round_sat(
    input logic signed [MAX_W-1:0] acc,
    input int frac_shift,
    input int out_w,
    input bit saturate
  );
    logic signed [MAX_W-1:0] one;
    logic signed [MAX_W-1:0] bias;
    logic signed [MAX_W-1:0] r;
    logic signed [MAX_W-1:0] max_v;
    logic signed [MAX_W-1:0] min_v;
    one = '0;
    one[0] = 1'b1;
    if (frac_shift > 0) begin
      bias = one <<< (frac_shift - 1);
      r = (acc + bias) >>> frac_shift;
    end else begin
      r = acc;
    end
    max_v = (one <<< (out_w - 1)) - one;
    min_v = ~max_v;
    if (saturate) begin
      if (r > max_v) r = max_v;
      else if (r < min_v) r = min_v;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational conversion of the full-precision accumulator to the output
// width: shift with round-half-up, then clamp or wrap.
module fir_round_sat
  import fir_pkg::*;
#(
  parameter int ACC_W      = 40,
  parameter int OUT_W      = 24,
  parameter int FRAC_SHIFT = 15,
  parameter int SATURATE   = 1
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] result
);

  logic signed [MAX_W-1:0] wide;
  logic                    unused_hi;

  // Sign-extend into the wide domain so the rounding bias can never overflow.
  always_comb begin
    wide   = round_sat(MAX_W'(acc), FRAC_SHIFT, OUT_W, SATURATE != 0);
    result = wide[OUT_W-1:0];
  end

  assign unused_hi = ^wide[MAX_W-1:OUT_W];

endmodule

// File: rtl/symmetric_fir_param.sv
// Symmetric linear-phase FIR in transposed form. Only ceil(N/2) products are
// formed per sample; each product feeds its two mirrored taps. Coefficients
// are written into a shadow bank and committed atomically to the active bank.
module symmetric_fir_param
  import fir_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int COEFF_W    = 16,
  parameter int OUT_W      = 24,
  parameter int NUM_TAPS   = 172,
  parameter int FRAC_SHIFT = 15,
  parameter int SATURATE   = 1,
  localparam int M         = num_mults(NUM_TAPS),
  localparam int ADDR_W    = addr_width(NUM_TAPS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic signed [DATA_W-1:0]  data_in,
  output logic signed [OUT_W-1:0]   data_out,
  output logic                      out_valid,
  input  logic                      coeff_we,
  input  logic        [ADDR_W-1:0]  coeff_addr,
  input  logic signed [COEFF_W-1:0] coeff_data,
  input  logic                      coeff_commit,
  output logic                      coeff_busy
);

  localparam int ACC_W  = acc_width(DATA_W, COEFF_W, NUM_TAPS);
  localparam int PROD_W = DATA_W + COEFF_W;
  localparam int SLOTS  = 1 << ADDR_W;

  logic signed [COEFF_W-1:0] shadow   [SLOTS];
  logic signed [COEFF_W-1:0] active   [SLOTS];
  logic signed [PROD_W-1:0]  mult     [M];
  logic signed [ACC_W-1:0]   tap      [NUM_TAPS];
  logic signed [ACC_W-1:0]   sum_next [NUM_TAPS];
  logic signed [ACC_W-1:0]   chain    [1:NUM_TAPS-1];
  logic signed [OUT_W-1:0]   rounded;

  // Shadow writes and atomic commit; the commit copies the pre-edge shadow.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SLOTS; s++) begin
        shadow[s] <= '0;
        active[s] <= '0;
      end
      coeff_busy <= 1'b0;
    end else begin
      if (coeff_commit) active <= shadow;
      if (coeff_we && (32'(coeff_addr) < M)) shadow[coeff_addr] <= coeff_data;
      coeff_busy <= coeff_commit;
    end
  end

  // Broadcast the new sample to all folded multipliers at full precision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < M; i++) mult[i] <= '0;
    end else if (en) begin
      for (int i = 0; i < M; i++) mult[i] <= PROD_W'(active[i]) * PROD_W'(data_in);
    end
  end

  // Map every tap to its folded product and build the adder chain inputs.
  for (genvar i = 0; i < NUM_TAPS; i++) begin : g_tap
    localparam int SRC = (i < M) ? i : NUM_TAPS - 1 - i;
    assign tap[i] = ACC_W'(mult[SRC]);
    if (i == NUM_TAPS - 1) begin : g_last
      assign sum_next[i] = tap[i];
    end else begin : g_mid
      assign sum_next[i] = chain[i + 1] + tap[i];
    end
  end

  // Transposed adder chain; stage 0 is consumed directly by the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NUM_TAPS; i++) chain[i] <= '0;
    end else if (en) begin
      for (int i = 1; i < NUM_TAPS; i++) chain[i] <= sum_next[i];
    end
  end

  fir_round_sat #(
    .ACC_W      (ACC_W),
    .OUT_W      (OUT_W),
    .FRAC_SHIFT (FRAC_SHIFT),
    .SATURATE   (SATURATE)
  ) u_round_sat (
    .acc    (sum_next[0]),
    .result (rounded)
  );

  // Registered output; holds while en is low, valid pulses one cycle after en.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= en;
      if (en) data_out <= rounded;
    end
  end

endmodule

// File: tb/tb_symmetric_fir_param.sv
// Directed bench for symmetric_fir_param: five instances with different
// tap counts, widths, rounding and saturation settings share one stimulus bus.
module tb_symmetric_fir_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, en, coeff_we, coeff_commit;
  logic signed [15:0] data_in, coeff_data;
  logic        [1:0]  coeff_addr;

  logic signed [23:0] e_out, o_out, r_out;
  logic signed [15:0] s_out, w_out;
  logic e_valid, o_valid, s_valid, w_valid, r_valid;
  logic e_busy, o_busy, s_busy, w_busy, r_busy;

  int compared   = 0;
  int mismatched = 0;

  longint hm [8];
  longint xs [64];
  int     nx;

  symmetric_fir_param #(.DATA_W(16), .COEFF_W(16), .OUT_W(24), .NUM_TAPS(8),
                        .FRAC_SHIFT(0), .SATURATE(1)) dut_e (
    .clk(clk), .reset(reset), .en(en), .data_in(data_in), .data_out(e_out),
    .out_valid(e_valid), .coeff_we(coeff_we), .coeff_addr(coeff_addr),
    .coeff_data(coeff_data), .coeff_commit(coeff_commit), .coeff_busy(e_busy));

  symmetric_fir_param #(.DATA_W(16), .COEFF_W(16), .OUT_W(24), .NUM_TAPS(7),
                        .FRAC_SHIFT(0), .SATURATE(1)) dut_o (
    .clk(clk), .reset(reset), .en(en), .data_in(data_in), .data_out(o_out),
    .out_valid(o_valid), .coeff_we(coeff_we), .coeff_addr(coeff_addr),
    .coeff_data(coeff_data), .coeff_commit(coeff_commit), .coeff_busy(o_busy));

  symmetric_fir_param #(.DATA_W(16), .COEFF_W(16), .OUT_W(16), .NUM_TAPS(8),
                        .FRAC_SHIFT(0), .SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .en(en), .data_in(data_in), .data_out(s_out),
    .out_valid(s_valid), .coeff_we(coeff_we), .coeff_addr(coeff_addr),
    .coeff_data(coeff_data), .coeff_commit(coeff_commit), .coeff_busy(s_busy));

  symmetric_fir_param #(.DATA_W(16), .COEFF_W(16), .OUT_W(16), .NUM_TAPS(8),
                        .FRAC_SHIFT(0), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .en(en), .data_in(data_in), .data_out(w_out),
    .out_valid(w_valid), .coeff_we(coeff_we), .coeff_addr(coeff_addr),
    .coeff_data(coeff_data), .coeff_commit(coeff_commit), .coeff_busy(w_busy));

  symmetric_fir_param #(.DATA_W(16), .COEFF_W(16), .OUT_W(24), .NUM_TAPS(2),
                        .FRAC_SHIFT(1), .SATURATE(1)) dut_r (
    .clk(clk), .reset(reset), .en(en), .data_in(data_in), .data_out(r_out),
    .out_valid(r_valid), .coeff_we(coeff_we), .coeff_addr(coeff_addr[0:0]),
    .coeff_data(coeff_data), .coeff_commit(coeff_commit), .coeff_busy(r_busy));

  // Direct-form convolution over the samples strobed since the last reset.
  function automatic longint model_sum(input int n);
    longint s;
    int     k;
    s = 0;
    k = nx - 1;
    for (int j = 0; j < n; j++) begin
      if (k - 1 - j >= 0) s += hm[j] * xs[k - 1 - j];
    end
    return s;
  endfunction

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint wrap16(input longint v);
    logic signed [15:0] t;
    t = v[15:0];
    return longint'(t);
  endfunction

  task automatic set_h4(input longint a, input longint b, input longint c, input longint d);
    hm[0] = a; hm[1] = b; hm[2] = c; hm[3] = d;
    hm[4] = d; hm[5] = c; hm[6] = b; hm[7] = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    nx = 0;
  endtask

  task automatic write_coeff(input int addr, input longint val);
    coeff_we   = 1'b1;
    coeff_addr = 2'(addr);
    coeff_data = 16'(val);
    tick();
    coeff_we = 1'b0;
  endtask

  task automatic commit_bank();
    coeff_commit = 1'b1;
    tick();
    coeff_commit = 1'b0;
  endtask

  task automatic strobe(input longint x);
    en      = 1'b1;
    data_in = 16'(x);
    xs[nx]  = x;
    nx++;
    tick();
    en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    nx = 0;
    compared += 15;
    if (e_out !== 24'sd0) begin mismatched++; $display("[TB] FAIL reset_e_out got %0d want 0", e_out); end
    if (o_out !== 24'sd0) begin mismatched++; $display("[TB] FAIL reset_o_out got %0d want 0", o_out); end
    if (s_out !== 16'sd0) begin mismatched++; $display("[TB] FAIL reset_s_out got %0d want 0", s_out); end
    if (w_out !== 16'sd0) begin mismatched++; $display("[TB] FAIL reset_w_out got %0d want 0", w_out); end
    if (r_out !== 24'sd0) begin mismatched++; $display("[TB] FAIL reset_r_out got %0d want 0", r_out); end
    if ({e_valid, o_valid, s_valid, w_valid, r_valid} !== 5'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_valid got %b want 00000", {e_valid, o_valid, s_valid, w_valid, r_valid});
    end
    if ({e_busy, o_busy, s_busy, w_busy, r_busy} !== 5'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_busy got %b want 00000", {e_busy, o_busy, s_busy, w_busy, r_busy});
    end
    compared -= 8;
  endtask

  task automatic test_impulse();
    int exp_e [9] = '{1, 2, 3, 4, 4, 3, 2, 1, 0};
    int exp_o [9] = '{1, 2, 3, 4, 3, 2, 1, 0, 0};
    do_reset();
    for (int a = 0; a < 4; a++) write_coeff(a, a + 1);
    commit_bank();
    strobe(1);
    compared += 3;
    if (e_out !== 24'sd0) begin mismatched++; $display("[TB] FAIL impulse_first_even got %0d want 0", e_out); end
    if (o_out !== 24'sd0) begin mismatched++; $display("[TB] FAIL impulse_first_odd got %0d want 0", o_out); end
    if (e_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL impulse_valid got %b want 1", e_valid); end
    for (int k = 0; k < 9; k++) begin
      strobe(0);
      compared += 2;
      if (e_out !== 24'(exp_e[k])) begin
        mismatched++;
        $display("[TB] FAIL impulse_even[%0d] got %0d want %0d", k, e_out, exp_e[k]);
      end
      if (o_out !== 24'(exp_o[k])) begin
        mismatched++;
        $display("[TB] FAIL impulse_odd[%0d] got %0d want %0d", k, o_out, exp_o[k]);
      end
    end
  endtask

  task automatic test_saturation();
    longint m, x, want_s, want_w;
    do_reset();
    for (int a = 0; a < 4; a++) write_coeff(a, 32767);
    commit_bank();
    set_h4(32767, 32767, 32767, 32767);
    for (int k = 0; k < 18; k++) begin
      x = (k < 9) ? 64'sd32767 : -64'sd32768;
      strobe(x);
      m      = model_sum(8);
      want_s = sat16(m);
      want_w = wrap16(m);
      compared += 2;
      if (s_out !== 16'(want_s)) begin
        mismatched++;
        $display("[TB] FAIL saturate[%0d] got %0d want %0d", k, s_out, want_s);
      end
      if (w_out !== 16'(want_w)) begin
        mismatched++;
        $display("[TB] FAIL wrap[%0d] got %0d want %0d", k, w_out, want_w);
      end
    end
  endtask

  task automatic test_rounding();
    int xin  [8] = '{1, 0, 0, 0, -1, 0, 0, 0};
    int want [8] = '{0, 2, 2, 0, 0, -1, -1, 0};
    do_reset();
    write_coeff(0, 3);
    write_coeff(1, 100);
    commit_bank();
    for (int k = 0; k < 8; k++) begin
      strobe(xin[k]);
      compared++;
      if (r_out !== 24'(want[k])) begin
        mismatched++;
        $display("[TB] FAIL rounding[%0d] got %0d want %0d", k, r_out, want[k]);
      end
    end
  endtask

  task automatic test_commit_timing();
    int want [10] = '{1, 5, 0, 0, 0, 0, 0, 1, 5, 0};
    int busy_seen;
    do_reset();
    write_coeff(0, 1);
    commit_bank();
    write_coeff(0, 5);
    coeff_commit = 1'b1;
    coeff_we     = 1'b1;
    coeff_addr   = 2'd0;
    coeff_data   = 16'sd7;
    strobe(1);
    coeff_commit = 1'b0;
    coeff_we     = 1'b0;
    compared += 2;
    if (e_out !== 24'sd0) begin mismatched++; $display("[TB] FAIL commit_cycle_out got %0d want 0", e_out); end
    if (e_busy !== 1'b1) begin mismatched++; $display("[TB] FAIL commit_busy got %b want 1", e_busy); end
    busy_seen = 0;
    for (int k = 0; k < 10; k++) begin
      strobe((k == 0) ? 1 : 0);
      if (e_busy === 1'b1) busy_seen++;
      compared++;
      if (e_out !== 24'(want[k])) begin
        mismatched++;
        $display("[TB] FAIL commit_seq[%0d] got %0d want %0d", k, e_out, want[k]);
      end
    end
    compared++;
    if (busy_seen !== 0) begin mismatched++; $display("[TB] FAIL busy_extra got %0d want 0", busy_seen); end
    commit_bank();
    compared += 2;
    if (e_busy !== 1'b1) begin mismatched++; $display("[TB] FAIL recommit_busy got %b want 1", e_busy); end
    if (e_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL recommit_valid got %b want 0", e_valid); end
    strobe(1);
    compared++;
    if (e_out !== 24'sd0) begin mismatched++; $display("[TB] FAIL recommit_first got %0d want 0", e_out); end
    strobe(0);
    compared++;
    if (e_out !== 24'sd7) begin mismatched++; $display("[TB] FAIL recommit_new_bank got %0d want 7", e_out); end
  endtask

  task automatic test_reset_midstream();
    longint m, held;
    do_reset();
    set_h4(1, 2, 3, 4);
    for (int a = 0; a < 4; a++) write_coeff(a, a + 1);
    commit_bank();
    for (int k = 0; k < 5; k++) begin
      strobe(1);
      m = model_sum(8);
      compared++;
      if (e_out !== 24'(m)) begin mismatched++; $display("[TB] FAIL step_pre[%0d] got %0d want %0d", k, e_out, m); end
    end
    reset   = 1'b1;
    en      = 1'b1;
    data_in = 16'sd1;
    tick();
    reset = 1'b0;
    en    = 1'b0;
    nx    = 0;
    compared += 2;
    if (e_out !== 24'sd0) begin mismatched++; $display("[TB] FAIL midreset_out got %0d want 0", e_out); end
    if (e_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_valid got %b want 0", e_valid); end
    for (int a = 0; a < 4; a++) write_coeff(a, a + 1);
    commit_bank();
    for (int k = 0; k < 10; k++) begin
      strobe(1);
      m = model_sum(8);
      compared += 2;
      if (e_out !== 24'(m)) begin mismatched++; $display("[TB] FAIL step_post[%0d] got %0d want %0d", k, e_out, m); end
      if (e_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL step_valid[%0d] got %b want 1", k, e_valid); end
      if (k == 2) begin
        held = m;
        for (int g = 0; g < 3; g++) begin
          tick();
          compared += 2;
          if (e_out !== 24'(held)) begin mismatched++; $display("[TB] FAIL gap_hold[%0d] got %0d want %0d", g, e_out, held); end
          if (e_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL gap_valid[%0d] got %b want 0", g, e_valid); end
        end
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    en           = 1'b0;
    coeff_we     = 1'b0;
    coeff_commit = 1'b0;
    coeff_addr   = '0;
    coeff_data   = '0;
    data_in      = '0;
    nx           = 0;
    test_reset();
    test_impulse();
    test_saturation();
    test_rounding();
    test_commit_timing();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
